// File: rtl/uart_rx_with_buffer.sv
// 8N1 UART receiver with a mid-bit sampling FSM feeding a show-ahead byte FIFO.
// Framing errors and FIFO overruns are reported as registered one-cycle pulses.
module uart_rx_with_buffer #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uartrx,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              data_available,
    output logic [ADDR_W:0]   count,
    output logic              fifo_full,
    output logic              framing_error,
    output logic              overrun
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    localparam logic [15:0]     HALF_T  = 16'(CLK_PER_BIT / 2 - 1);
    localparam logic [15:0]     FULL_T  = 16'(CLK_PER_BIT - 1);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic              rx_s;
    logic [15:0]       timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              fe_q, fe_d, ovr_q, ovr_d;
    logic              bit_tick, push_req, push, pop, full, empty;
    logic [7:0]        mem_q [FIFO_DEPTH];

    assign rx_s = sync2_q;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bit_tick  = 1'b0;
        push_req  = 1'b0;
        fe_d      = 1'b0;
        case (state_q)
            IDLE: if (!rx_s) state_d = START;
            START: if (timer_q == HALF_T) begin
                bit_tick = 1'b1;
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: if (timer_q == FULL_T) begin
                bit_tick          = 1'b1;
                shift_d[bit_idx_q] = rx_s;
                if (bit_idx_q == 3'd7) state_d = STOP;
                else                   bit_idx_d = bit_idx_q + 3'd1;
            end
            STOP: if (timer_q == FULL_T) begin
                bit_tick = 1'b1;
                if (rx_s) begin
                    push_req = 1'b1;
                    state_d  = IDLE;
                end else begin
                    fe_d    = 1'b1;
                    state_d = BRK;
                end
            end
            BRK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Restart the bit timer on each sample so consecutive DATA bits stay one bit apart.
        timer_d = (bit_tick || (state_d != state_q)) ? 16'd0 : timer_q + 16'd1;
    end

    always_comb begin
        full     = (count_q == DEPTH_C);
        empty    = (count_q == '0);
        pop      = rd_en && !empty;
        // At full, a same-cycle pop frees the head slot, which is where the new byte lands.
        push     = push_req && (!full || pop);
        ovr_d    = push_req && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (ADDR_W + 1)'(1);
        else if (pop && !push) count_d = count_q - (ADDR_W + 1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= uartrx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rd_data        = mem_q[rd_ptr_q];
    assign data_available = !empty;
    assign count          = count_q;
    assign fifo_full      = full;
    assign framing_error  = fe_q;
    assign overrun        = ovr_q;

endmodule
